usb2_ep_in_queue: RTL and testbench
===================================

Name: usb2_ep_in_queue

Overview:
- Parametrised successor to the single-buffer IN endpoint handshake: manages a ring of NUM_SLOTS packet slots for one IN endpoint, all in the phy_clk (60 MHz ULPI) domain.
- Sits between the endpoint buffer RAM (producer side: commit/commit_len/commit_ack) and the packet layer (consumer side: hasdata/len/start/ack/retry).
- Adds multi-packet queuing, replay of un-ACKed packets, and DATA0/DATA1 toggle tracking, none of which the single-buffer scheme has.

Parameters:
- ADDR_W, 9, byte-address width of one slot; max packet = 2^ADDR_W bytes.
- NUM_SLOTS, 2, number of packet slots; power of two, minimum 2.
- SLOT_W, 1, log2(NUM_SLOTS); must be consistent with NUM_SLOTS.

Ports:
- phy_clk  in  1  ULPI clock, 60 MHz.
- reset_n  in  1  asynchronous active-low reset.
- buf_in_commit  in  1  producer commit request, four-phase level.
- buf_in_commit_len  in  ADDR_W+1  byte length of the committed packet.
- buf_in_commit_ack  out  1  commit acknowledge, four-phase.
- buf_in_ready  out  1  a free slot exists.
- wr_slot  out  SLOT_W  slot the producer fills next (RAM upper address bits).
- rd_slot  out  SLOT_W  slot the packet layer reads.
- buf_out_hasdata  out  1  head slot valid and not in flight.
- buf_out_len  out  ADDR_W+1  length of the head slot.
- pkt_start  in  1  one-cycle pulse: packet layer begins sending the head slot.
- pkt_acked  in  1  one-cycle pulse: host ACK received.
- pkt_retry  in  1  one-cycle pulse: timeout or no handshake; resend.
- toggle_reset  in  1  one-cycle pulse: force the next packet to DATA0.
- data_toggle  out  1  PID of the head packet: 0 = DATA0, 1 = DATA1.
- occupancy  out  SLOT_W+1  number of committed, un-freed slots.

Behaviour:
- Reset state: all outputs 0; wr_ptr = rd_ptr = 0; count = 0; both FSMs idle. buf_in_ready goes to 1 one cycle after reset release.
- Derived outputs: buf_in_ready = (count != NUM_SLOTS); occupancy = count; wr_slot = wr_ptr; rd_slot = rd_ptr.
- Producer FSM, states C_IDLE and C_ACK:
  - C_IDLE: if buf_in_commit=1 and count < NUM_SLOTS, then len_ram[wr_ptr] <= commit_len, wr_ptr++ (wraps modulo NUM_SLOTS), count++, go to C_ACK. buf_in_commit_ack is registered and rises on the cycle after acceptance.
  - If the ring is full, the commit is held: no ack until a slot frees.
  - C_ACK: buf_in_commit_ack=1 until buf_in_commit=0, then return to C_IDLE with ack=0. Only one packet is accepted per four-phase cycle.
- commit_len greater than 2^ADDR_W saturates to 2^ADDR_W. commit_len=0 is a valid zero-length packet and still raises hasdata.
- Consumer FSM, states R_IDLE and R_FLIGHT:
  - buf_out_hasdata = (count != 0) and state == R_IDLE.
  - buf_out_len = len_ram[rd_ptr], combinational read.
  - R_IDLE: pkt_start with hasdata=1 goes to R_FLIGHT. pkt_start with hasdata=0 is ignored.
  - R_FLIGHT: pkt_acked alone: rd_ptr++, count--, data_toggle flips, go to R_IDLE.
  - R_FLIGHT: pkt_retry, alone or together with pkt_acked: rd_ptr, count and toggle unchanged, go to R_IDLE. The same slot is resent with the same PID; the host discards the duplicate by PID.
  - pkt_acked or pkt_retry in R_IDLE is ignored.
- Acceptance and free in the same cycle: count unchanged, both pointers advance.
- toggle_reset: data_toggle <= 0 on the next edge in any state. It has priority over an ACK-flip in the same cycle. Queue contents are unaffected.
- Asynchronous reset mid-operation discards all slots; an outstanding commit must re-handshake.

Optional Feature:
- USB2_EP_ISO_EN defined: adds input iso_mode (1 bit).
  - With iso_mode=1, pkt_retry is ignored and a slot frees on pkt_acked or on the first cycle of R_FLIGHT + 1 when the packet layer pulses pkt_acked (isochronous transfers have no handshake, so the packet layer pulses pkt_acked at end of transmit).
  - With iso_mode=1, data_toggle is held at 0.
- USB2_EP_ISO_EN undefined: no iso_mode port; bulk/interrupt behaviour only.

Test Plan:
- Reset, then commit len=64 -> ack rises 1 cycle later, occupancy=1, hasdata=1, buf_out_len=64, rd_slot=0, wr_slot=1, data_toggle=0.
- NUM_SLOTS=2: commit 3 packets (10, 20, 30) back-to-back -> third held with ack=0 and buf_in_ready=0 until first pkt_start+pkt_acked. Then the third is accepted, occupancy stays 2, wr_slot wraps to 1.
- pkt_start then pkt_retry on len=512 -> hasdata returns to 1, len=512, toggle=0, occupancy unchanged. pkt_start then pkt_acked -> toggle=1, occupancy=0, hasdata=0.
- Same cycle: commit accepted while pkt_acked frees -> occupancy unchanged, both pointers +1. Same cycle pkt_acked and pkt_retry -> treated as retry.
- toggle_reset in the same cycle as pkt_acked with toggle=1 -> toggle=0. commit_len=1023 with ADDR_W=9 -> buf_out_len=512. commit_len=0 -> hasdata=1, len=0.
- With USB2_EP_ISO_EN and iso_mode=1: pkt_retry is ignored, pkt_acked frees the slot, toggle stays 0 across 4 packets.

Source files
------------

// File: rtl/usb2_ep_in_queue_if.sv
// ---------------------------------------------------------------------------
// usb2_ep_in_queue_if
//   Handshake bundle for the IN-endpoint packet ring.
//   master : the endpoint-side agents (buffer RAM producer + packet layer).
//   slave  : the queue itself (usb2_ep_in_queue).
//   Producer side : buf_in_commit, buf_in_commit_len, buf_in_commit_ack,
//                   buf_in_ready, wr_slot
//   Consumer side : buf_out_hasdata, buf_out_len, rd_slot, pkt_start,
//                   pkt_acked, pkt_retry, toggle_reset, data_toggle
//   Status        : occupancy
//   Optional      : iso_mode, present only when USB2_EP_ISO_EN is defined.
// ---------------------------------------------------------------------------
interface usb2_ep_in_queue_if #(
  parameter int ADDR_W = 9,
  parameter int SLOT_W = 1
);
  logic              buf_in_commit;
  logic [ADDR_W:0]   buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic              buf_in_ready;
  logic [SLOT_W-1:0] wr_slot;
  logic [SLOT_W-1:0] rd_slot;
  logic              buf_out_hasdata;
  logic [ADDR_W:0]   buf_out_len;
  logic              pkt_start;
  logic              pkt_acked;
  logic              pkt_retry;
  logic              toggle_reset;
  logic              data_toggle;
  logic [SLOT_W:0]   occupancy;
`ifdef USB2_EP_ISO_EN
  logic              iso_mode;
`endif

  modport master (
`ifdef USB2_EP_ISO_EN
    output iso_mode,
`endif
    output buf_in_commit, buf_in_commit_len, pkt_start, pkt_acked,
           pkt_retry, toggle_reset,
    input  buf_in_commit_ack, buf_in_ready, wr_slot, rd_slot,
           buf_out_hasdata, buf_out_len, data_toggle, occupancy
  );

  modport slave (
`ifdef USB2_EP_ISO_EN
    input  iso_mode,
`endif
    input  buf_in_commit, buf_in_commit_len, pkt_start, pkt_acked,
           pkt_retry, toggle_reset,
    output buf_in_commit_ack, buf_in_ready, wr_slot, rd_slot,
           buf_out_hasdata, buf_out_len, data_toggle, occupancy
  );
endinterface

// File: rtl/usb2_ep_in_queue.sv
// ---------------------------------------------------------------------------
// usb2_ep_in_queue
//   Ring of NUM_SLOTS packet slots for one USB2 IN endpoint (phy_clk domain).
//   The producer commits a filled slot with a four-phase commit/ack
//   handshake; the packet layer sends the head slot (pkt_start) and then
//   either frees it (pkt_acked) or keeps it for replay (pkt_retry).
//   DATA0/DATA1 toggle flips on every freed packet.
//
//   Ports:
//     phy_clk  : 60 MHz ULPI clock
//     reset_n  : asynchronous active-low reset; discards all slots
//     bus      : usb2_ep_in_queue_if.slave (producer + consumer handshakes)
//
//   Build option: USB2_EP_ISO_EN adds bus.iso_mode. With iso_mode=1 retries
//   are ignored, pkt_acked always frees the in-flight slot and the toggle
//   is held at DATA0.
// ---------------------------------------------------------------------------
module usb2_ep_in_queue #(
  parameter int ADDR_W    = 9,
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 1
) (
  input  logic               phy_clk,
  input  logic               reset_n,
  usb2_ep_in_queue_if.slave  bus
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [SLOT_W:0] FULL    = (SLOT_W+1)'(NUM_SLOTS);

  typedef enum logic { C_IDLE, C_ACK    } c_state_t;
  typedef enum logic { R_IDLE, R_FLIGHT } r_state_t;

  c_state_t          c_state;
  r_state_t          r_state;
  logic [SLOT_W-1:0] wr_ptr;
  logic [SLOT_W-1:0] rd_ptr;
  logic [SLOT_W:0]   count;
  logic [ADDR_W:0]   len_ram [NUM_SLOTS];
  logic              commit_ack_q;
  logic              ready_q;
  logic              toggle_q;

  logic              iso;
  logic              accept;
  logic              start;
  logic              retry_hit;
  logic              free_slot;
  logic              flight_end;
  logic [ADDR_W:0]   sat_len;
  logic [SLOT_W:0]   count_next;

`ifdef USB2_EP_ISO_EN
  assign iso = bus.iso_mode;
`else
  assign iso = 1'b0;
`endif

  // Lengths above one slot's capacity are clamped rather than wrapped.
  assign sat_len = (bus.buf_in_commit_len > MAX_LEN) ? MAX_LEN : bus.buf_in_commit_len;

  assign accept     = (c_state == C_IDLE) && bus.buf_in_commit && (count < FULL);
  assign start      = (r_state == R_IDLE) && bus.pkt_start && (count != '0);
  // Retry wins over a simultaneous ACK: replaying is always safe because
  // the host drops the duplicate by PID.
  assign retry_hit  = (r_state == R_FLIGHT) && bus.pkt_retry && !iso;
  assign free_slot  = (r_state == R_FLIGHT) && bus.pkt_acked && !retry_hit;
  assign flight_end = free_slot || retry_hit;

  always_comb begin
    count_next = count;
    if (accept && !free_slot)      count_next = count + 1'b1;
    else if (free_slot && !accept) count_next = count - 1'b1;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      c_state      <= C_IDLE;
      r_state      <= R_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      commit_ack_q <= 1'b0;
      ready_q      <= 1'b0;
      toggle_q     <= 1'b0;
      // NOTE: the length table is reset so buf_out_len reads 0 out of reset;
      // it is only NUM_SLOTS words, so flops are the natural implementation.
      for (int i = 0; i < NUM_SLOTS; i++) len_ram[i] <= '0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != FULL);

      // Producer: one packet per four-phase commit cycle.
      unique case (c_state)
        C_IDLE: if (accept) begin
          len_ram[wr_ptr] <= sat_len;
          wr_ptr          <= wr_ptr + 1'b1;
          commit_ack_q    <= 1'b1;
          c_state         <= C_ACK;
        end
        C_ACK: if (!bus.buf_in_commit) begin
          commit_ack_q <= 1'b0;
          c_state      <= C_IDLE;
        end
      endcase

      // Consumer: head slot is either idle (offerable) or in flight.
      unique case (r_state)
        R_IDLE:   if (start) r_state <= R_FLIGHT;
        R_FLIGHT: if (flight_end) r_state <= R_IDLE;
      endcase

      if (free_slot) rd_ptr <= rd_ptr + 1'b1;

      if (bus.toggle_reset || iso) toggle_q <= 1'b0;
      else if (free_slot)          toggle_q <= ~toggle_q;
    end
  end

  assign bus.buf_in_commit_ack = commit_ack_q;
  assign bus.buf_in_ready      = ready_q;
  assign bus.wr_slot           = wr_ptr;
  assign bus.rd_slot           = rd_ptr;
  assign bus.occupancy         = count;
  assign bus.data_toggle       = toggle_q;
  assign bus.buf_out_hasdata   = (count != '0) && (r_state == R_IDLE);
  assign bus.buf_out_len       = len_ram[rd_ptr];

endmodule

// File: tb/tb_usb2_ep_in_queue.sv
// ---------------------------------------------------------------------------
// tb_usb2_ep_in_queue
//   Self-checking bench for usb2_ep_in_queue (ADDR_W=9, NUM_SLOTS=2).
//   A queue-of-lengths reference model predicts every output after every
//   clock; directed scenarios cover the corner cases, then a randomized
//   phase exercises interleaved commits, starts, ACKs, retries and toggle
//   resets, followed by an asynchronous reset in mid-traffic.
// ---------------------------------------------------------------------------
module tb_usb2_ep_in_queue;
  localparam int ADDR_W    = 9;
  localparam int NUM_SLOTS = 2;
  localparam int SLOT_W    = 1;
  localparam int MAX_LEN   = 1 << ADDR_W;

  logic phy_clk = 1'b0;
  logic reset_n = 1'b0;

  usb2_ep_in_queue_if #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W)) bus ();

  usb2_ep_in_queue #(.ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) dut (
    .phy_clk (phy_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #8 phy_clk = ~phy_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_q[$];          // lengths of committed, un-freed packets, head first
  int m_wr, m_rd;      // slot numbers, counted modulo NUM_SLOTS
  bit m_flight;        // head packet handed to the packet layer
  bit m_acking;        // producer handshake in its ack phase
  bit m_toggle;
  bit m_ready;
  bit m_iso;

  task automatic model_reset();
    m_q.delete();
    m_wr = 0; m_rd = 0;
    m_flight = 0; m_acking = 0; m_toggle = 0; m_ready = 0;
  endtask

  task automatic compare_all();
    check("ack",       int'(bus.buf_in_commit_ack), int'(m_acking));
    check("ready",     int'(bus.buf_in_ready),      int'(m_ready));
    check("wr_slot",   int'(bus.wr_slot),           m_wr);
    check("rd_slot",   int'(bus.rd_slot),           m_rd);
    check("occupancy", int'(bus.occupancy),         m_q.size());
    check("hasdata",   int'(bus.buf_out_hasdata),   int'(m_q.size() != 0 && !m_flight));
    check("toggle",    int'(bus.data_toggle),       int'(m_toggle));
    if (m_q.size() != 0) check("len", int'(bus.buf_out_len), m_q[0]);
  endtask

  // One clock: predict from the pre-edge inputs, then compare just after the edge.
  task automatic step();
    bit commit, st, ak, rt, tr, acc, fre, rty, stt;
    int len;
    commit = bus.buf_in_commit;
    len    = int'(bus.buf_in_commit_len);
    st = bus.pkt_start; ak = bus.pkt_acked; rt = bus.pkt_retry; tr = bus.toggle_reset;
    acc = !m_acking && commit && (m_q.size() < NUM_SLOTS);
    stt = !m_flight && st && (m_q.size() != 0);
    rty = m_flight && rt && !m_iso;
    fre = m_flight && ak && !rty;
    @(posedge phy_clk);
    #1;
    if (fre) begin
      void'(m_q.pop_front());
      m_rd = (m_rd + 1) % NUM_SLOTS;
      m_toggle = !m_toggle;
    end
    if (acc) begin
      m_q.push_back(len > MAX_LEN ? MAX_LEN : len);
      m_wr = (m_wr + 1) % NUM_SLOTS;
      m_acking = 1;
    end else if (m_acking && !commit) begin
      m_acking = 0;
    end
    if (stt) m_flight = 1;
    else if (fre || rty) m_flight = 0;
    if (tr || m_iso) m_toggle = 0;
    m_ready = (m_q.size() != NUM_SLOTS);
    compare_all();
  endtask

  task automatic pulse(input bit st, input bit ak, input bit rt, input bit tr);
    bus.pkt_start = st; bus.pkt_acked = ak; bus.pkt_retry = rt; bus.toggle_reset = tr;
    step();
    bus.pkt_start = 0; bus.pkt_acked = 0; bus.pkt_retry = 0; bus.toggle_reset = 0;
  endtask

  task automatic do_commit(input int len);
    bus.buf_in_commit = 1; bus.buf_in_commit_len = (ADDR_W+1)'(len);
    step();
    bus.buf_in_commit = 0;
    step();
  endtask

  task automatic send_head(); // start, then ACK
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
  endtask

  task automatic drive_idle();
    bus.buf_in_commit = 0; bus.buf_in_commit_len = '0;
    bus.pkt_start = 0; bus.pkt_acked = 0; bus.pkt_retry = 0; bus.toggle_reset = 0;
`ifdef USB2_EP_ISO_EN
    bus.iso_mode = 0;
`endif
  endtask

  initial begin
    drive_idle();
    model_reset();
    m_iso = 0;

    // Reset: everything reads zero.
    #20;
    check("rst_ack",   int'(bus.buf_in_commit_ack), 0);
    check("rst_ready", int'(bus.buf_in_ready),      0);
    check("rst_has",   int'(bus.buf_out_hasdata),   0);
    check("rst_len",   int'(bus.buf_out_len),       0);
    check("rst_occ",   int'(bus.occupancy),         0);
    check("rst_tog",   int'(bus.data_toggle),       0);
    @(negedge phy_clk);
    reset_n = 1;
    step();
    check("ready_after_rst", int'(bus.buf_in_ready), 1);

    // Single commit of 64 bytes.
    bus.buf_in_commit = 1; bus.buf_in_commit_len = 64;
    step();
    check("c64_ack", int'(bus.buf_in_commit_ack), 1);
    check("c64_len", int'(bus.buf_out_len), 64);
    check("c64_wr",  int'(bus.wr_slot), 1);
    bus.buf_in_commit = 0;
    step();
    send_head();
    check("c64_tog", int'(bus.data_toggle), 1);

    // Full ring holds the third commit until a slot frees.
    do_commit(10);
    do_commit(20);
    bus.buf_in_commit = 1; bus.buf_in_commit_len = 30;
    repeat (3) step();
    check("held_ack",   int'(bus.buf_in_commit_ack), 0);
    check("held_ready", int'(bus.buf_in_ready), 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    step();
    check("held_acc_ack", int'(bus.buf_in_commit_ack), 1);
    check("held_acc_occ", int'(bus.occupancy), 2);
    bus.buf_in_commit = 0;
    step();
    send_head(); send_head();

    // Retry keeps the 512-byte packet and its PID; ACK then frees it.
    do_commit(512);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    check("retry_len", int'(bus.buf_out_len), 512);
    check("retry_has", int'(bus.buf_out_hasdata), 1);
    send_head();
    check("ack_occ", int'(bus.occupancy), 0);

    // Accept and free in the same cycle; ACK+retry together acts as retry.
    do_commit(7);
    pulse(1, 0, 0, 0);
    bus.buf_in_commit = 1; bus.buf_in_commit_len = 5;
    pulse(0, 1, 0, 0);
    check("same_occ", int'(bus.occupancy), 1);
    bus.buf_in_commit = 0;
    step();
    pulse(1, 0, 0, 0);
    pulse(0, 1, 1, 0);
    check("ackretry_occ", int'(bus.occupancy), 1);

    // toggle_reset beats an ACK-flip.
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 1);
    check("treset_tog", int'(bus.data_toggle), 0);

    // Saturating and zero lengths.
    do_commit(1023);
    check("sat_len", int'(bus.buf_out_len), 512);
    send_head();
    do_commit(0);
    check("zlp_has", int'(bus.buf_out_hasdata), 1);
    check("zlp_len", int'(bus.buf_out_len), 0);
    send_head();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.buf_in_commit && $urandom_range(0, 2) == 0) begin
        bus.buf_in_commit = 1;
        bus.buf_in_commit_len = (ADDR_W+1)'($urandom_range(0, 1023));
      end else if (bus.buf_in_commit && m_acking && $urandom_range(0, 1) == 0) begin
        bus.buf_in_commit = 0;
      end
      bus.pkt_start    = ($urandom_range(0, 9) < 3);
      bus.pkt_acked    = ($urandom_range(0, 9) < 3);
      bus.pkt_retry    = ($urandom_range(0, 9) < 1);
      bus.toggle_reset = ($urandom_range(0, 31) == 0);
      step();
    end

    // Asynchronous reset mid-traffic discards everything.
    bus.buf_in_commit = 1; bus.buf_in_commit_len = 33;
    bus.pkt_start = 0; bus.pkt_acked = 0; bus.pkt_retry = 0; bus.toggle_reset = 0;
    step();
    #3 reset_n = 0;
    #1;
    check("mrst_occ", int'(bus.occupancy), 0);
    check("mrst_ack", int'(bus.buf_in_commit_ack), 0);
    check("mrst_has", int'(bus.buf_out_hasdata), 0);
    model_reset();
    drive_idle();
    @(negedge phy_clk);
    reset_n = 1;
    step();
    do_commit(77);
    send_head();

`ifdef USB2_EP_ISO_EN
    // Isochronous: retry ignored, ACK frees, toggle pinned to DATA0.
    bus.iso_mode = 1; m_iso = 1;
    for (int p = 0; p < 4; p++) begin
      do_commit(100 + p);
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      check("iso_tog", int'(bus.data_toggle), 0);
    end
    bus.iso_mode = 0; m_iso = 0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
